a2d_scan_sched: RTL
===================

// Module: a2d_scan_sched
// PURPOSE
//  Sequences the shared A2D interface for the line-sensor datapath. Per scan: enables each IR emitter
//  pair in turn, waits settle time, converts left/right channels, publishes all six results atomically.
//  Also arbitrates one auxiliary requester (battery/diagnostic) onto the same A2D, serviced only with
//  all emitters off. Sits between dig_core motion logic and A2D_intf.
// PARAMETERS
//  NUM_PAIRS    3       emitter pairs scanned (in, mid, out), 1..3
//  SETTLE_CYC   4096    clk cycles from emitter enable to first strt_cnv of that pair
//  TIMEOUT_CYC  2048    max clk cycles strt_cnv->cnv_cmplt before conversion is declared failed
//  AUX_CHNL     3'd6    A2D channel used for the auxiliary requester
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  scan_go    in   1   1-cycle pulse: start one full scan
//  scan_busy  out  1   high from accepted scan_go until scan_done
//  scan_done  out  1   1-cycle pulse: results updated this cycle
//  scan_err   out  1   sticky; set on conversion timeout, cleared by next accepted scan_go
//  IR_in_en / IR_mid_en / IR_out_en  out 1 each  emitter enables, pair 0/1/2
//  strt_cnv   out  1   1-cycle pulse to A2D_intf
//  chnnl      out  3   channel select, stable from strt_cnv until cnv_cmplt
//  cnv_cmplt  in   1   conversion done from A2D_intf
//  A2D_res    in   12  conversion result, valid while cnv_cmplt high
//  lft_res    out  36  {pair2,pair1,pair0} left results, 12 b each
//  rht_res    out  36  {pair2,pair1,pair0} right results
//  aux_req    in   1   level: aux requester wants one conversion
//  aux_gnt    out  1   1-cycle pulse when aux conversion starts
//  aux_vld    out  1   1-cycle pulse: aux_res updated
//  aux_res    out  12  last aux result
// BEHAVIOUR
//  Reset: every output 0 (emitters off, results 0, chnnl 0); FSM->IDLE; counters 0. Reset mid-scan
//   aborts immediately, no scan_done, results keep reset value 0.
//  FSM: IDLE -> SETTLE -> CNV_L -> WAIT_L -> CNV_R -> WAIT_R -> NEXT -> (SETTLE | DONE) -> IDLE;
//   AUX_CNV -> AUX_WAIT -> return state (IDLE or SETTLE of next pair).
//  IDLE: aux_req has priority over scan_go if both seen same cycle; scan_go then ignored (not queued).
//   scan_go while busy ignored.
//  SETTLE: only emitter of current pair p high; count SETTLE_CYC cycles, then CNV_L.
//  CNV_L/CNV_R: strt_cnv=1 one cycle, chnnl=LFT_CHNL[p]/RHT_CHNL[p]; WAIT_*: capture A2D_res into
//   shadow reg on cnv_cmplt. cnv_cmplt in same cycle as strt_cnv is not accepted.
//  Timeout: TIMEOUT_CYC cycles in WAIT_* without cnv_cmplt -> emitters off, scan_err=1, IDLE,
//   no scan_done, published results unchanged.
//  NEXT: emitter off. If aux_req high -> service aux (emitters all off) before next pair's SETTLE.
//   Bounds aux latency to one pair. After last pair -> DONE.
//  DONE: copy shadow->lft_res/rht_res, scan_done=1, scan_busy=0 next cycle. Results never partial.
//  Aux: aux_gnt coincides with strt_cnv (chnnl=AUX_CHNL); aux_res/aux_vld on cnv_cmplt+1.
//   Aux timeout: aux_vld not pulsed, scan_err=1, sequence resumes.
//  Exactly one emitter high at any time, and none during aux conversion.
//  Counters: settle 13 b, timeout 12 b, sized $clog2 of params; saturate, never wrap.
// STRUCTURE
//  Package a2d_sched_pkg: state enum, LFT_CHNL={3'd1,3'd4,3'd3}, RHT_CHNL={3'd0,3'd2,3'd7}.
//  One sub-module natural: a2d_cyc_timer (load/expire down-counter) shared by settle and timeout.
// TESTING  (SETTLE_CYC=16, TIMEOUT_CYC=64; ADC128S model returns channel-coded values)
//  1 scan_go, model returns 0x100+chnnl -> lft_res={0x103,0x104,0x101}, rht={0x107,0x102,0x100},
//    one scan_done, 6 strt_cnv pulses, each emitter high >=16 cycles before its strt_cnv.
//  2 aux_req held during pair 0 -> aux_gnt after pair 0, chnnl=6, all IR_*_en=0, aux_vld, scan resumes pair 1.
//  3 aux_req and scan_go same cycle in IDLE -> aux first, scan_go dropped, scan_busy stays 0.
//  4 model withholds cnv_cmplt on pair 1 right -> scan_err=1 after 64 cycles, no scan_done,
//    results unchanged; next scan_go clears scan_err, completes.
//  5 rst asserted during SETTLE of pair 2 -> all outputs 0 same cycle, next scan_go runs from pair 0.
//  6 scan_go pulsed while busy -> ignored; exactly one scan_done, 6 conversions.

Source files
------------

// File: rtl/a2d_sched_pkg.sv
// Shared types and channel maps for the A2D scan scheduler.
package a2d_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CNV_L,
    ST_WAIT_L,
    ST_CNV_R,
    ST_WAIT_R,
    ST_NEXT,
    ST_DONE,
    ST_AUX_CNV,
    ST_AUX_WAIT
  } sched_state_t;

  // Index = emitter pair (0 in, 1 mid, 2 out).
  localparam logic [2:0] LFT_CHNL [3] = '{3'd1, 3'd4, 3'd3};
  localparam logic [2:0] RHT_CHNL [3] = '{3'd0, 3'd2, 3'd7};

  function automatic logic [2:0] pair_chnl(input logic [1:0] pair, input logic rht);
    logic [2:0] ch;
    case (pair)
      2'd0:    ch = rht ? RHT_CHNL[0] : LFT_CHNL[0];
      2'd1:    ch = rht ? RHT_CHNL[1] : LFT_CHNL[1];
      2'd2:    ch = rht ? RHT_CHNL[2] : LFT_CHNL[2];
      default: ch = 3'd0;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/a2d_cyc_timer.sv
// Load/expire down-counter shared by settle and conversion-timeout timing.
module a2d_cyc_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Stops at zero rather than wrapping, so a stale timer reads as expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/a2d_scan_sched.sv
// Scans IR emitter pairs through the shared A2D and publishes results atomically;
// also slots one auxiliary conversion in between pairs or while idle.
//
// state     | meaning
// IDLE      | waiting for aux_req (priority) or scan_go
// SETTLE    | emitter of current pair on, settle timer running
// CNV_L/R   | strt_cnv pulse on left/right channel of current pair
// WAIT_L/R  | waiting for cnv_cmplt, timeout timer running
// NEXT      | emitters off; pick aux, next pair or finish
// DONE      | results published, scan_done pulse
// AUX_CNV   | strt_cnv + aux_gnt on AUX_CHNL, emitters off
// AUX_WAIT  | waiting for aux cnv_cmplt, then return to IDLE or SETTLE
module a2d_scan_sched
  import a2d_sched_pkg::*;
#(
  parameter int         NUM_PAIRS   = 3,
  parameter int         SETTLE_CYC  = 4096,
  parameter int         TIMEOUT_CYC = 2048,
  parameter logic [2:0] AUX_CHNL    = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_go,
  output logic        scan_busy,
  output logic        scan_done,
  output logic        scan_err,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  output logic [35:0] lft_res,
  output logic [35:0] rht_res,
  input  logic        aux_req,
  output logic        aux_gnt,
  output logic        aux_vld,
  output logic [11:0] aux_res
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int TMR_W = (SET_W > TO_W) ? SET_W : TO_W;
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       LAST_PAIR  = 2'(NUM_PAIRS - 1);

  sched_state_t state, nxt;
  logic [1:0]  pair;
  logic        ret_scan;
  logic [35:0] shd_lft, shd_rht;

  logic             tmr_load, tmr_exp;
  logic [TMR_W-1:0] tmr_val;
  logic pair_clr, pair_inc, ret_set, ret_clr, err_set, err_clr;
  logic cap_l, cap_r, publish, aux_cap, emit_on;

  a2d_cyc_timer #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    tmr_load  = 1'b0;
    tmr_val   = SETTLE_LD;
    pair_clr  = 1'b0;
    pair_inc  = 1'b0;
    ret_set   = 1'b0;
    ret_clr   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    cap_l     = 1'b0;
    cap_r     = 1'b0;
    publish   = 1'b0;
    aux_cap   = 1'b0;
    emit_on   = 1'b0;
    strt_cnv  = 1'b0;
    aux_gnt   = 1'b0;
    chnnl     = 3'd0;
    scan_done = 1'b0;
    scan_busy = 1'b1;
    case (state)
      ST_IDLE: begin
        scan_busy = 1'b0;
        if (aux_req) begin
          nxt     = ST_AUX_CNV;
          ret_clr = 1'b1;
        end else if (scan_go) begin
          nxt      = ST_SETTLE;
          tmr_load = 1'b1;
          pair_clr = 1'b1;
          err_clr  = 1'b1;
        end
      end
      ST_SETTLE: begin
        emit_on = 1'b1;
        if (tmr_exp) nxt = ST_CNV_L;
      end
      ST_CNV_L: begin
        emit_on  = 1'b1;
        strt_cnv = 1'b1;
        chnnl    = pair_chnl(pair, 1'b0);
        tmr_load = 1'b1;
        tmr_val  = TIMEOUT_LD;
        nxt      = ST_WAIT_L;
      end
      ST_WAIT_L: begin
        emit_on = 1'b1;
        chnnl   = pair_chnl(pair, 1'b0);
        if (cnv_cmplt) begin
          cap_l = 1'b1;
          nxt   = ST_CNV_R;
        end else if (tmr_exp) begin
          err_set = 1'b1;
          nxt     = ST_IDLE;
        end
      end
      ST_CNV_R: begin
        emit_on  = 1'b1;
        strt_cnv = 1'b1;
        chnnl    = pair_chnl(pair, 1'b1);
        tmr_load = 1'b1;
        tmr_val  = TIMEOUT_LD;
        nxt      = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        emit_on = 1'b1;
        chnnl   = pair_chnl(pair, 1'b1);
        if (cnv_cmplt) begin
          cap_r = 1'b1;
          nxt   = ST_NEXT;
        end else if (tmr_exp) begin
          err_set = 1'b1;
          nxt     = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (pair == LAST_PAIR) begin
          publish = 1'b1;
          nxt     = ST_DONE;
        end else begin
          pair_inc = 1'b1;
          // Aux is slotted here so its wait never exceeds one pair.
          if (aux_req) begin
            ret_set = 1'b1;
            nxt     = ST_AUX_CNV;
          end else begin
            tmr_load = 1'b1;
            nxt      = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        scan_done = 1'b1;
        nxt       = ST_IDLE;
      end
      ST_AUX_CNV: begin
        scan_busy = ret_scan;
        strt_cnv  = 1'b1;
        aux_gnt   = 1'b1;
        chnnl     = AUX_CHNL;
        tmr_load  = 1'b1;
        tmr_val   = TIMEOUT_LD;
        nxt       = ST_AUX_WAIT;
      end
      ST_AUX_WAIT: begin
        scan_busy = ret_scan;
        chnnl     = AUX_CHNL;
        if (cnv_cmplt || tmr_exp) begin
          aux_cap = cnv_cmplt;
          err_set = !cnv_cmplt;
          if (ret_scan) begin
            tmr_load = 1'b1;
            nxt      = ST_SETTLE;
          end else begin
            nxt = ST_IDLE;
          end
        end
      end
      default: begin
        scan_busy = 1'b0;
        nxt       = ST_IDLE;
      end
    endcase
  end

  assign IR_in_en  = emit_on && (pair == 2'd0);
  assign IR_mid_en = emit_on && (pair == 2'd1);
  assign IR_out_en = emit_on && (pair == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair     <= 2'd0;
      ret_scan <= 1'b0;
      scan_err <= 1'b0;
      aux_vld  <= 1'b0;
      aux_res  <= 12'd0;
    end else begin
      if (pair_clr)      pair <= 2'd0;
      else if (pair_inc) pair <= pair + 2'd1;
      if (ret_set)      ret_scan <= 1'b1;
      else if (ret_clr) ret_scan <= 1'b0;
      if (err_set)      scan_err <= 1'b1;
      else if (err_clr) scan_err <= 1'b0;
      aux_vld <= aux_cap;
      if (aux_cap) aux_res <= A2D_res;
    end
  end

  // Shadow holds the scan in progress; the outputs only change on a full scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_lft <= 36'd0;
      shd_rht <= 36'd0;
      lft_res <= 36'd0;
      rht_res <= 36'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cap_l && pair == 2'(i)) shd_lft[12*i +: 12] <= A2D_res;
        if (cap_r && pair == 2'(i)) shd_rht[12*i +: 12] <= A2D_res;
      end
      if (publish) begin
        lft_res <= shd_lft;
        rht_res <= shd_rht;
      end
    end
  end

endmodule
